// File: rtl/error_supervisor_if.sv
// error_supervisor_if: bundles the error strobes and the status/reset outputs
// of the per-channel error supervisor.
// Optional ERROR_SUPERVISOR_LIFETIME_EN adds the lifetime counter signals.
interface error_supervisor_if #(
    parameter int CH_NUM = 3,
    parameter int CNT_W  = 16
);
    logic [CH_NUM-1:0]       iERR;
    logic                    oRST_RECEIVER;
    logic [CH_NUM*CNT_W-1:0] oERR_CNT;
    logic [CH_NUM-1:0]       oTRIP_CH;
    logic [15:0]             oTRIP_CNT;
    logic                    oBUSY;
`ifdef ERROR_SUPERVISOR_LIFETIME_EN
    logic                    iCLR_LIFE;
    logic [CH_NUM*32-1:0]    oLIFE_CNT;

    modport master (output iERR, output iCLR_LIFE,
                    input oRST_RECEIVER, input oERR_CNT, input oTRIP_CH,
                    input oTRIP_CNT, input oBUSY, input oLIFE_CNT);
    modport slave  (input iERR, input iCLR_LIFE,
                    output oRST_RECEIVER, output oERR_CNT, output oTRIP_CH,
                    output oTRIP_CNT, output oBUSY, output oLIFE_CNT);
`else
    modport master (output iERR,
                    input oRST_RECEIVER, input oERR_CNT, input oTRIP_CH,
                    input oTRIP_CNT, input oBUSY);
    modport slave  (input iERR,
                    output oRST_RECEIVER, output oERR_CNT, output oTRIP_CH,
                    output oTRIP_CNT, output oBUSY);
`endif
endinterface

// File: rtl/error_supervisor.sv
// error_supervisor: per-channel leaky error counters for the BLVDS receive
// path. When any channel exceeds ERR_NUM the receiver gets a RST_LEN-clock
// reset pulse followed by a HOLDOFF-clock quiet period, then monitoring
// resumes. Optional macro ERROR_SUPERVISOR_LIFETIME_EN adds per-channel 32-bit
// lifetime error counters that ignore trips and decay.
module error_supervisor #(
    parameter int CH_NUM  = 3,
    parameter int CNT_W   = 16,
    parameter int ERR_NUM = 5,
    parameter int RST_LEN = 8,
    parameter int HOLDOFF = 64,
    parameter int WIN_LEN = 1024
) (
    input  logic               iCLK,
    input  logic               iRST,
    error_supervisor_if.slave  bus
);
    localparam int TMR_MAX = (RST_LEN > HOLDOFF) ? RST_LEN : HOLDOFF;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int PS_W    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

    localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(RST_LEN - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD  = TMR_W'(HOLDOFF - 1);
    localparam logic [PS_W-1:0]  PS_LAST    = PS_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THRESH     = CNT_W'(ERR_NUM);

    typedef enum logic [1:0] {
        ST_MONITOR = 2'd0,
        ST_PULSE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    state_t             r_state;
    logic [TMR_W-1:0]   r_timer;
    logic [PS_W-1:0]    r_ps;
    logic [CH_NUM-1:0]  r_err;
    logic [CNT_W-1:0]   r_cnt [CH_NUM];
    logic               r_rst_rx;
    logic               r_busy;
    logic [CH_NUM-1:0]  r_trip_ch;
    logic [15:0]        r_trip_cnt;

    logic               w_tick;
    logic [CH_NUM-1:0]  w_over;
    logic [CH_NUM*CNT_W-1:0] w_err_cnt;

    // Register the raw error strobes; all counting works from this copy.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_err <= '0;
        end else begin
            r_err <= bus.iERR;
        end
    end

    // Free-running decay prescaler; wraps after WIN_LEN clocks in every state.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_ps <= '0;
        end else if (WIN_LEN <= 1) begin
            r_ps <= '0;
        end else if (r_ps == PS_LAST) begin
            r_ps <= '0;
        end else begin
            r_ps <= r_ps + PS_W'(1);
        end
    end

    assign w_tick = (WIN_LEN != 0) && (r_ps == PS_LAST);

    // Per-channel over-threshold flags and packed counter view.
    always_comb begin
        w_over    = '0;
        w_err_cnt = '0;
        for (int n = 0; n < CH_NUM; n++) begin
            w_over[n]                 = (r_cnt[n] > THRESH);
            w_err_cnt[n*CNT_W +: CNT_W] = r_cnt[n];
        end
    end

    // Supervisor FSM: counting, trip capture, reset pulse and hold-off timing.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state    <= ST_MONITOR;
            r_timer    <= '0;
            r_rst_rx   <= 1'b0;
            r_busy     <= 1'b0;
            r_trip_ch  <= '0;
            r_trip_cnt <= 16'd0;
            for (int n = 0; n < CH_NUM; n++) begin
                r_cnt[n] <= '0;
            end
        end else begin
            case (r_state)
                ST_MONITOR: begin
                    if (|w_over) begin
                        r_state   <= ST_PULSE;
                        r_rst_rx  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_trip_ch <= w_over;
                        r_timer   <= PULSE_LOAD;
                        if (r_trip_cnt != 16'hFFFF) begin
                            r_trip_cnt <= r_trip_cnt + 16'd1;
                        end
                        for (int n = 0; n < CH_NUM; n++) begin
                            r_cnt[n] <= '0;
                        end
                    end else begin
                        // An error and a decay tick together cancel out.
                        for (int n = 0; n < CH_NUM; n++) begin
                            if (r_err[n] && !w_tick) begin
                                if (r_cnt[n] != CNT_MAX) begin
                                    r_cnt[n] <= r_cnt[n] + CNT_W'(1);
                                end
                            end else if (!r_err[n] && w_tick && (r_cnt[n] != '0)) begin
                                r_cnt[n] <= r_cnt[n] - CNT_W'(1);
                            end
                        end
                    end
                end
                ST_PULSE: begin
                    if (r_timer == '0) begin
                        r_rst_rx <= 1'b0;
                        if (HOLDOFF > 0) begin
                            r_state <= ST_HOLDOFF;
                            r_timer <= HOLD_LOAD;
                        end else begin
                            r_state <= ST_MONITOR;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                ST_HOLDOFF: begin
                    if (r_timer == '0) begin
                        r_state <= ST_MONITOR;
                        r_busy  <= 1'b0;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                default: begin
                    r_state  <= ST_MONITOR;
                    r_timer  <= '0;
                    r_rst_rx <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oRST_RECEIVER = r_rst_rx;
    assign bus.oERR_CNT      = w_err_cnt;
    assign bus.oTRIP_CH      = r_trip_ch;
    assign bus.oTRIP_CNT     = r_trip_cnt;
    assign bus.oBUSY         = r_busy;

`ifdef ERROR_SUPERVISOR_LIFETIME_EN
    logic [31:0]          r_life [CH_NUM];
    logic [CH_NUM*32-1:0] w_life;

    // Lifetime counters: count every registered error in every state.
    always_ff @(posedge iCLK) begin
        if (iRST || bus.iCLR_LIFE) begin
            for (int n = 0; n < CH_NUM; n++) begin
                r_life[n] <= 32'd0;
            end
        end else begin
            for (int n = 0; n < CH_NUM; n++) begin
                if (r_err[n] && (r_life[n] != 32'hFFFF_FFFF)) begin
                    r_life[n] <= r_life[n] + 32'd1;
                end
            end
        end
    end

    // Pack lifetime counters for the output bus.
    always_comb begin
        w_life = '0;
        for (int n = 0; n < CH_NUM; n++) begin
            w_life[n*32 +: 32] = r_life[n];
        end
    end

    assign bus.oLIFE_CNT = w_life;
`endif

endmodule

// File: tb/tb_error_supervisor.sv
// tb_error_supervisor: two supervisors (no decay / WIN_LEN=16) driven by the
// same strobes, compared every cycle against a timeline-based reference model,
// plus directed scenarios with hand-derived expectations.
module tb_error_supervisor;
    localparam int CH   = 3;
    localparam int CW   = 16;
    localparam int ERRN = 5;
    localparam int RL   = 8;
    localparam int HO   = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] err_in;
    logic          clr_life;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    error_supervisor_if #(.CH_NUM(CH), .CNT_W(CW)) bus0 ();
    error_supervisor_if #(.CH_NUM(CH), .CNT_W(CW)) bus1 ();

    assign bus0.iERR = err_in;
    assign bus1.iERR = err_in;
`ifdef ERROR_SUPERVISOR_LIFETIME_EN
    assign bus0.iCLR_LIFE = clr_life;
    assign bus1.iCLR_LIFE = clr_life;
`endif

    error_supervisor #(.CH_NUM(CH), .CNT_W(CW), .ERR_NUM(ERRN), .RST_LEN(RL),
                       .HOLDOFF(HO), .WIN_LEN(0))
        u_dut0 (.iCLK(clk), .iRST(rst), .bus(bus0.slave));

    error_supervisor #(.CH_NUM(CH), .CNT_W(CW), .ERR_NUM(ERRN), .RST_LEN(RL),
                       .HOLDOFF(HO), .WIN_LEN(16))
        u_dut1 (.iCLK(clk), .iRST(rst), .bus(bus1.slave));

    // ---------------- reference model (timeline arithmetic) ----------------
    int            win [2] = '{0, 16};
    int            cyc = 0;
    int            rst_edge = 0;
    bit            valid = 1'b0;
    int            m_cnt  [2][CH];
    longint        m_life [2][CH];
    logic [CH-1:0] m_rerr [2];
    int            m_trip_t [2];
    logic [CH-1:0] m_tch  [2];
    int            m_tcnt [2];

    task automatic model_edge();
        bit            tick;
        bit            mon;
        logic [CH-1:0] over;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                valid       = 1'b1;
                rst_edge    = cyc;
                m_trip_t[k] = -1000000;
                m_tch[k]    = '0;
                m_tcnt[k]   = 0;
                m_rerr[k]   = '0;
                for (int n = 0; n < CH; n++) begin
                    m_cnt[k][n]  = 0;
                    m_life[k][n] = 0;
                end
            end else begin
                tick = (win[k] != 0) && (((cyc - rst_edge) % win[k]) == 0);
                mon  = cyc > (m_trip_t[k] + RL + HO);
                if (mon) begin
                    over = '0;
                    for (int n = 0; n < CH; n++) over[n] = (m_cnt[k][n] > ERRN);
                    if (over != '0) begin
                        m_trip_t[k] = cyc;
                        m_tch[k]    = over;
                        if (m_tcnt[k] < 65535) m_tcnt[k]++;
                        for (int n = 0; n < CH; n++) m_cnt[k][n] = 0;
                    end else begin
                        for (int n = 0; n < CH; n++) begin
                            if (m_rerr[k][n] && !tick) begin
                                if (m_cnt[k][n] < 65535) m_cnt[k][n]++;
                            end else if (tick && !m_rerr[k][n] && m_cnt[k][n] > 0) begin
                                m_cnt[k][n]--;
                            end
                        end
                    end
                end
                for (int n = 0; n < CH; n++) begin
                    if (clr_life) m_life[k][n] = 0;
                    else if (m_rerr[k][n] && m_life[k][n] < 64'hFFFF_FFFF) m_life[k][n]++;
                end
                m_rerr[k] = err_in;
            end
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cmp_inst(input int k, input logic rrx, input logic busy,
                            input logic [CH-1:0] tch, input logic [15:0] tcnt,
                            input logic [CH*CW-1:0] ecnt, input logic [CH*32-1:0] life,
                            input bit use_life);
        logic [CH*CW-1:0] e_cnt;
        logic [CH*32-1:0] e_life;
        bit               e_rrx;
        bit               e_busy;
        for (int n = 0; n < CH; n++) begin
            e_cnt[n*CW +: CW]  = CW'(m_cnt[k][n]);
            e_life[n*32 +: 32] = 32'(m_life[k][n]);
        end
        e_rrx  = (cyc >= m_trip_t[k]) && (cyc < m_trip_t[k] + RL);
        e_busy = (cyc >= m_trip_t[k]) && (cyc < m_trip_t[k] + RL + HO);
        chk($sformatf("i%0d_rst_rx", k), {127'd0, rrx}, {127'd0, e_rrx});
        chk($sformatf("i%0d_busy", k), {127'd0, busy}, {127'd0, e_busy});
        chk($sformatf("i%0d_trip_ch", k), 128'(tch), 128'(m_tch[k]));
        chk($sformatf("i%0d_trip_cnt", k), 128'(tcnt), 128'(m_tcnt[k]));
        chk($sformatf("i%0d_err_cnt", k), 128'(ecnt), 128'(e_cnt));
        if (use_life) chk($sformatf("i%0d_life", k), 128'(life), 128'(e_life));
    endtask

    // Compare process: every cycle once the model has seen a reset.
    initial begin
        logic [CH*32-1:0] l0;
        logic [CH*32-1:0] l1;
        bit               ul;
        forever begin
            @(negedge clk);
            if (valid) begin
`ifdef ERROR_SUPERVISOR_LIFETIME_EN
                l0 = bus0.oLIFE_CNT; l1 = bus1.oLIFE_CNT; ul = 1'b1;
`else
                l0 = '0; l1 = '0; ul = 1'b0;
`endif
                cmp_inst(0, bus0.oRST_RECEIVER, bus0.oBUSY, bus0.oTRIP_CH, bus0.oTRIP_CNT,
                         bus0.oERR_CNT, l0, ul);
                cmp_inst(1, bus1.oRST_RECEIVER, bus1.oBUSY, bus1.oTRIP_CH, bus1.oTRIP_CNT,
                         bus1.oERR_CNT, l1, ul);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic logic get_rst(input int k);
        return (k == 0) ? bus0.oRST_RECEIVER : bus1.oRST_RECEIVER;
    endfunction

    task automatic wait_rst(input int k, input logic lvl, input string name);
        int i;
        i = 0;
        while (get_rst(k) !== lvl && i < 300) begin
            step();
            i++;
        end
        chk(name, {127'd0, get_rst(k)}, {127'd0, lvl});
    endtask

    initial begin
        int n;
        int t_a;
        int t_b;
        rst = 1'b1; err_in = '0; clr_life = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_busy", {127'd0, bus0.oBUSY}, 128'd0);
        chk("rst_trip_cnt", 128'(bus0.oTRIP_CNT), 128'd0);
        chk("rst_err_cnt", 128'(bus1.oERR_CNT), 128'd0);

        // T1: six strobes on channel 1, no decay
        err_in = 3'b010;
        repeat (6) step();
        err_in = 3'b000;
        step();
        chk("t1_cnt6", 128'(bus0.oERR_CNT[1*CW +: CW]), 128'd6);
        chk("t1_rst_lo", {127'd0, bus0.oRST_RECEIVER}, 128'd0);
        step();
        chk("t1_rst_hi", {127'd0, bus0.oRST_RECEIVER}, 128'd1);
        chk("t1_trip_ch", 128'(bus0.oTRIP_CH), 128'(3'b010));
        chk("t1_trip_cnt", 128'(bus0.oTRIP_CNT), 128'd1);
        chk("t1_cnt_clr", 128'(bus0.oERR_CNT), 128'd0);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus0.oRST_RECEIVER) n++;
        end
        chk("t1_pulse_len", 128'(n), 128'd8);

        // T2: channels 0 and 2 cross together
        do_reset();
        err_in = 3'b101;
        repeat (6) step();
        err_in = 3'b000;
        step();
        chk("t2_cnt", 128'(bus0.oERR_CNT), 128'h0006_0000_0006);
        step();
        chk("t2_trip_ch", 128'(bus0.oTRIP_CH), 128'(3'b101));
        chk("t2_trip_cnt", 128'(bus0.oTRIP_CNT), 128'd1);

        // T3: errors held through pulse and hold-off
        do_reset();
        err_in = 3'b001;
        wait_rst(0, 1'b1, "t3_first_trip");
        t_a = cyc;
        wait_rst(0, 1'b0, "t3_pulse_end");
        wait_rst(0, 1'b1, "t3_second_trip");
        t_b = cyc;
        chk("t3_period", 128'(t_b - t_a), 128'd79);
        err_in = 3'b000;

        // T4: decay window 16, strobes aligned with the tick
        do_reset();
        for (int j = 1; j <= 100; j++) begin
            err_in = ((j % 16) == 15) ? 3'b001 : 3'b000;
            step();
        end
        err_in = 3'b000;
        chk("t4_aligned_cnt", 128'(bus1.oERR_CNT[CW-1:0]), 128'd0);
        chk("t4_aligned_trips", 128'(bus1.oTRIP_CNT), 128'd0);

        // T4b: strobes every 8 clocks -> net +1 per window
        do_reset();
        for (int j = 1; j <= 100; j++) begin
            err_in = ((j % 8) == 7) ? 3'b001 : 3'b000;
            step();
        end
        err_in = 3'b000;
        chk("t4b_trips", 128'(bus1.oTRIP_CNT), 128'd1);
        chk("t4b_trip_ch", 128'(bus1.oTRIP_CH), 128'(3'b001));

        // T5: reset in the third pulse cycle
        do_reset();
        err_in = 3'b010;
        repeat (6) step();
        err_in = 3'b000;
        wait_rst(0, 1'b1, "t5_trip");
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rst_rx", {127'd0, bus0.oRST_RECEIVER}, 128'd0);
        chk("t5_trip_cnt", 128'(bus0.oTRIP_CNT), 128'd0);
        chk("t5_trip_ch", 128'(bus0.oTRIP_CH), 128'd0);
        chk("t5_busy", {127'd0, bus0.oBUSY}, 128'd0);

`ifdef ERROR_SUPERVISOR_LIFETIME_EN
        // Lifetime: ten errors across a trip, then clear coincident with an error
        do_reset();
        err_in = 3'b001;
        repeat (10) step();
        err_in = 3'b000;
        step();
        chk("life_ten", 128'(bus0.oLIFE_CNT[31:0]), 128'd10);
        err_in = 3'b001;
        step();
        err_in = 3'b000;
        clr_life = 1'b1;
        step();
        clr_life = 1'b0;
        chk("life_clr", 128'(bus0.oLIFE_CNT[31:0]), 128'd0);
`endif

        // Randomized phase, density changes every 400 cycles
        for (int blk = 0; blk < 10; blk++) begin
            int dens;
            dens = $urandom_range(2, 60);
            for (int i = 0; i < 400; i++) begin
                for (int b = 0; b < CH; b++) err_in[b] = ($urandom_range(0, 99) < dens);
                rst      = ($urandom_range(0, 999) == 0);
                clr_life = ($urandom_range(0, 199) == 0);
                step();
            end
        end
        rst = 1'b0; err_in = '0; clr_life = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/error_supervisor.md
Name: error_supervisor

Overview:
- Parametrised per-channel error supervisor for the BLVDS receive path.
- Takes CH_NUM single-cycle error strobes (overflow, header, epilogue, CRC, ...) and keeps a saturating counter per channel. The counters leak down over a programmable window.
- When any channel exceeds its threshold, it issues a timed synchronous reset pulse to the receiver, then a hold-off period, then resumes monitoring.
- Reports per-channel counts, which channel(s) tripped, and the total number of trips.

Parameters:
- CH_NUM, 3: number of error channels (1..16).
- CNT_W, 16: width of each per-channel error counter.
- ERR_NUM, 5: trip threshold; trip when count > ERR_NUM (must be < 2^CNT_W-1).
- RST_LEN, 8: receiver reset pulse length in clocks (>=1).
- HOLDOFF, 64: clocks after the pulse during which errors are ignored (0 allowed).
- WIN_LEN, 1024: decay period in clocks; every WIN_LEN clocks each non-zero counter decrements by 1; 0 disables decay.

Ports:
- iCLK  in  1  clock, single domain.
- iRST  in  1  synchronous reset, active-high.
- iERR  in  CH_NUM  error strobes, bit n = channel n, one count per high cycle.
- oRST_RECEIVER  out  1  synchronous reset to BLVDS receiver, active-high.
- oERR_CNT  out  CH_NUM*CNT_W  packed counters, channel n at [n*CNT_W +: CNT_W].
- oTRIP_CH  out  CH_NUM  channels above threshold at the last trip; held until next trip or iRST.
- oTRIP_CNT  out  16  number of trips since iRST, saturating at 16'hFFFF.
- oBUSY  out  1  high while state != MONITOR.

Behaviour:
- Clock and reset: one clock, iCLK. Reset iRST is synchronous and active-high.
- Reset values: all counters 0, rERR 0, state MONITOR, oRST_RECEIVER 0, oTRIP_CH 0, oTRIP_CNT 0, oBUSY 0, timers 0, decay prescaler 0.
- iRST asserted mid-operation (including mid-pulse) forces reset values on the next edge; the pulse is cut short.
- Input stage: iERR is registered into rERR at every edge. Counters use rERR only.
- Counter update, state MONITOR only:
  - rERR[n]=1 and no decay tick: +1, saturating at all-ones.
  - Decay tick and rERR[n]=0: -1 if non-zero.
  - Both together: unchanged.
  - Neither: unchanged.
- Decay prescaler: free-running 0..WIN_LEN-1, tick when it equals WIN_LEN-1. It runs in all states and restarts at 0 on iRST. With WIN_LEN=0 there is never a tick.
- Trip detect (registered compare): in MONITOR, if any counter > ERR_NUM at an edge, that edge does all of the following:
  - State goes to PULSE.
  - oRST_RECEIVER goes to 1.
  - oTRIP_CH is loaded with the per-channel (count > ERR_NUM) vector.
  - oTRIP_CNT increments (saturating).
  - All counters clear to 0.
  - The pulse timer loads RST_LEN-1.
- Latency: iERR high in the cycle before edge k is sampled into rERR at edge k, the counter updates at edge k+1, and the trip registers at edge k+2. oRST_RECEIVER is therefore high from edge k+2 of the (ERR_NUM+1)-th counted error.
- States:
  - MONITOR: counting; oBUSY=0.
  - PULSE: oRST_RECEIVER=1 for exactly RST_LEN clocks. Counters are held at 0 and rERR is ignored. On timer==0: go to HOLDOFF with timer=HOLDOFF-1 if HOLDOFF>0, else go to MONITOR. oRST_RECEIVER drops on the same edge.
  - HOLDOFF: oRST_RECEIVER=0, rERR ignored, counters held at 0. On timer==0, go to MONITOR.
- Errors arriving in the last HOLDOFF cycle are ignored. The first error counted is the one sampled into rERR at the edge entering MONITOR, visible in the first MONITOR cycle.
- Multiple channels crossing in the same cycle: all their bits are set in oTRIP_CH; it is one trip, and oTRIP_CNT increments by 1.
- oERR_CNT is driven directly from the counter registers (no extra latency).

Optional Feature:
- Macro: ERROR_SUPERVISOR_LIFETIME_EN.
- Defined: adds ports iCLR_LIFE (in, 1) and oLIFE_CNT (out, CH_NUM*32).
  - Per-channel 32-bit saturating lifetime counters increment on rERR[n] in every state, including PULSE and HOLDOFF.
  - They are unaffected by trips and decay, and are cleared by iRST or by iCLR_LIFE (synchronous).
  - If iCLR_LIFE and rERR[n] occur in the same cycle, the counter clears to 0.
- Undefined: those ports and registers are absent; all other behaviour is identical.

Test Plan:
- Defaults, WIN_LEN=0: 6 single-cycle strobes on iERR[1] -> oERR_CNT ch1 reaches 6; oRST_RECEIVER high 2 edges after the 6th is sampled, for exactly 8 clocks; oTRIP_CH=3'b010; oTRIP_CNT=1; all counts 0.
- iERR[0] and iERR[2] reach count 6 in the same cycle -> single trip, oTRIP_CH=3'b101, oTRIP_CNT=1.
- Errors held high throughout PULSE and HOLDOFF (72 clocks) -> counters stay 0. After return to MONITOR, counting restarts at 1 and the next trip occurs 6 counted cycles later.
- WIN_LEN=16, one error strobe every 16 clocks aligned with the decay tick -> counter never changes; with strobes every 8 clocks -> net +1 per 16 clocks, trip at count 6.
- iRST asserted in the 3rd PULSE cycle -> next edge: oRST_RECEIVER=0, oTRIP_CNT=0, oTRIP_CH=0, state MONITOR.
- ERROR_SUPERVISOR_LIFETIME_EN defined: 10 errors on ch0 across a trip -> oLIFE_CNT ch0=10. Pulse iCLR_LIFE coincident with an error -> oLIFE_CNT ch0=0.
